mat_scan_arb: RTL and testbench
===============================

Name: mat_scan_arb

Overview:
Block-granular round-robin arbiter that shares one mat_sacn matrix scanner between two upstream requesters. It grants one requester for a whole N*N-sample block and muxes that requester's stream into the scanner. It tags each in-flight block with its source ID and re-attaches the tag, plus a last-beat marker, to the scanner's output stream. It sits between two pixel/coefficient producers and the scanner, with the scanner's output returned through it.

Parameters:
DW, 10, sample width (matches scanner din/dout)
N, 8, matrix dimension; block length BL = N*N = 64 beats
TAGD, 2, tag FIFO depth = maximum blocks in flight inside scanner (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_vld  in  2  per-requester beat valid
req_din0  in  DW  requester 0 data
req_din1  in  DW  requester 1 data
req_rdy  out  2  per-requester ready; beat accepted when req_vld[i] & req_rdy[i]
scan_vld  out  1  to scanner vld_in
scan_din  out  DW  to scanner din
scan_vld_out  in  1  from scanner vld_out
scan_dout  in  DW  from scanner dout
out_vld  out  1  output beat valid
out_dout  out  DW  output data
out_src  out  1  source requester of current output block
out_last  out  1  high on final (BL-th) beat of an output block
err_gap  out  1  sticky: granted requester dropped req_vld mid-block
err_orphan  out  1  sticky: scanner output with tag FIFO empty

Behaviour:
- Reset (rst high at posedge): state IDLE, last-served pointer = 1, beat counters = 0, tag FIFO empty, both err flags cleared. While in reset and afterwards until granted: req_rdy = 0, scan_vld = 0, scan_din = 0, out_* = 0.
- Clock/reset fixed: one clock; reset is synchronous and active-high (ports clk, rst).
- States: IDLE, BUSY, STALL.
- IDLE: if tag FIFO full -> STALL. Else if any req_vld: select winner, register gnt, push gnt into tag FIFO, go BUSY next cycle. Otherwise stay.
- Winner rule: sole requester wins. If both request, the requester != last-served wins. After reset, requester 0 wins first.
- STALL: leave to IDLE on the cycle after a tag pop makes the FIFO non-full.
- BUSY: req_rdy[gnt] = 1, other bit 0.
  - scan_vld = req_vld[gnt], scan_din = granted din. Combinational mux, zero latency.
  - When req_vld[gnt] is low, scan_din = 0.
- In-block counter in_cnt increments per accepted beat. On the accepted beat with in_cnt == BL-1: in_cnt <- 0, last-served <- gnt, state <- IDLE.
- One idle bubble between consecutive blocks is mandatory; req_rdy = 0 in IDLE.
- Gap: in BUSY, req_vld[gnt] low after the block's first beat and before its last -> err_gap set (sticky until rst). Counting resumes on later beats; no abort.
- Output side: out_vld = scan_vld_out, out_dout = scan_dout (combinational).
  - out_src = tag FIFO head.
  - Counter out_cnt counts scan_vld_out beats. out_last = scan_vld_out & (out_cnt == BL-1).
  - On the out_last beat: pop the tag, out_cnt <- 0.
- scan_vld_out with tag FIFO empty: err_orphan set, out_src = 0, no pop.
- Simultaneous tag push (grant) and pop (out_last) in one cycle: both take effect, occupancy unchanged.
- Counter widths: clog2(BL) bits; the BL-1 compare is the only wrap.
- Reset mid-block: abandons the block and tags immediately. Upstream and scanner must also be reset.

Decomposition:
- Package mat_scan_pkg: DW, N, BL, clog2(BL) count width, state enum {IDLE, BUSY, STALL}.
- One sub-module: mat_scan_tagfifo, a TAGD-deep 1-bit synchronous FIFO with push/pop/full/empty and simultaneous push+pop.

Test Plan:
1. Single block: after rst, req_vld=01, req_din0 counts 0..63 continuously.
   -> Grant next cycle; scan_din 0..63 over 64 cycles; req_rdy=00 for one cycle after.
   -> Scanner output tagged out_src=0; out_last on 64th out beat.
2. Contention: both req_vld held high from reset release.
   -> Blocks alternate 0,1,0,1, each 64 beats with a 1-cycle bubble.
   -> out_src sequence 0,1,0,1 matches the output blocks.
3. Tag-full stall: TAGD=2, scanner output held off (scan_vld_out=0) for 3 blocks' time.
   -> After 2 granted blocks the state is STALL and req_rdy=00.
   -> The first out_last pop resumes granting within 2 cycles.
4. Gap: requester 0 drops req_vld for 5 cycles at beat 20.
   -> err_gap=1 and stays 1.
   -> Block completes after 64 accepted beats; scan_vld low during the gap.
5. Orphan: pulse scan_vld_out with no grant ever made.
   -> err_orphan=1, out_src=0, out_vld follows input.
6. Reset mid-block: assert rst at beat 30 of a block.
   -> Next cycle: req_rdy=00, scan_vld=0, err flags 0.
   -> Fresh request re-granted to requester 0 with in_cnt starting at 0.

Source files
------------

// File: rtl/mat_scan_pkg.sv
// Shared constants and state encoding for the block-granular scanner arbiter.
package mat_scan_pkg;
  localparam int DW = 10;
  localparam int N  = 8;
  localparam int BL = N * N;
  localparam int CW = $clog2(BL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    STALL = 2'd2
  } state_t;
endpackage

// File: rtl/mat_scan_tagfifo.sv
// Small 1-bit source-tag FIFO; push and pop may occur in the same cycle.
module mat_scan_tagfifo #(
  parameter int TAGD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(TAGD);

  logic [TAGD-1:0] mem;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // An empty FIFO reports source 0 so orphan beats carry a defined tag.
  assign dout    = empty ? 1'b0 : mem[rd_ptr[AW-1:0]];

  // Pointer and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/mat_scan_arb.sv
// Round-robin, block-granular arbiter sharing one matrix scanner between two
// requesters; tags scanner output with its source and marks the last beat.
module mat_scan_arb
  import mat_scan_pkg::*;
#(
  parameter int TAGD = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_vld,
  input  logic [DW-1:0] req_din0,
  input  logic [DW-1:0] req_din1,
  output logic [1:0]    req_rdy,
  output logic          scan_vld,
  output logic [DW-1:0] scan_din,
  input  logic          scan_vld_out,
  input  logic [DW-1:0] scan_dout,
  output logic          out_vld,
  output logic [DW-1:0] out_dout,
  output logic          out_src,
  output logic          out_last,
  output logic          err_gap,
  output logic          err_orphan
);
  state_t        state;
  state_t        state_nx;
  logic          gnt;
  logic          last_srv;
  logic          win;
  logic          acc;
  logic          push;
  logic          pop;
  logic          tag_full;
  logic          tag_empty;
  logic          tag_head;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;

  mat_scan_tagfifo #(.TAGD(TAGD)) u_tagfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (win),
    .pop   (pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Next-state, grant selection and the zero-latency input mux.
  always_comb begin
    state_nx = state;
    push     = 1'b0;
    win      = 1'b0;
    acc      = 1'b0;
    req_rdy  = 2'b00;
    scan_vld = 1'b0;
    scan_din = {DW{1'b0}};
    case (state)
      IDLE: begin
        if (tag_full) begin
          state_nx = STALL;
        end else if (req_vld != 2'b00) begin
          win      = (req_vld == 2'b11) ? ~last_srv : req_vld[1];
          push     = 1'b1;
          state_nx = BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        req_rdy  = gnt ? 2'b10 : 2'b01;
        acc      = req_vld[gnt];
        scan_vld = acc;
        if (acc) begin
          scan_din = gnt ? req_din1 : req_din0;
        end else begin
          scan_din = {DW{1'b0}};
        end
        if (acc && (in_cnt == CW'(BL - 1))) begin
          state_nx = IDLE;
        end else begin
          state_nx = BUSY;
        end
      end
      STALL: begin
        if (pop) begin
          state_nx = IDLE;
        end else begin
          state_nx = STALL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Input-side state: FSM, grant, fairness pointer, beat count, gap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_srv <= 1'b1;
      in_cnt   <= {CW{1'b0}};
      err_gap  <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) begin
        gnt <= win;
      end
      if (acc) begin
        if (in_cnt == CW'(BL - 1)) begin
          in_cnt   <= {CW{1'b0}};
          last_srv <= gnt;
        end else begin
          in_cnt <= in_cnt + CW'(1);
        end
      end
      // A missing beat only counts as a gap once the block has started.
      if ((state == BUSY) && !req_vld[gnt] && (in_cnt != {CW{1'b0}})) begin
        err_gap <= 1'b1;
      end
    end
  end

  assign out_vld  = scan_vld_out;
  assign out_dout = scan_dout;
  assign out_src  = tag_head;
  assign out_last = scan_vld_out & (out_cnt == CW'(BL - 1));
  assign pop      = out_last & ~tag_empty;

  // Output-side beat count and orphan detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt    <= {CW{1'b0}};
      err_orphan <= 1'b0;
    end else begin
      if (scan_vld_out) begin
        out_cnt <= out_last ? {CW{1'b0}} : out_cnt + CW'(1);
      end
      if (scan_vld_out && tag_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mat_scan_arb.sv
// Self-checking bench for mat_scan_arb: FIFO-order scanner model, scoreboard
// on the tagged output stream, table of arbitration vectors, corner sequences.
module tb_mat_scan_arb;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_vld = 2'b00;
  logic [9:0] req_din0 = 10'd0;
  logic [9:0] req_din1 = 10'd0;
  logic [1:0] req_rdy;
  logic       scan_vld;
  logic [9:0] scan_din;
  logic       scan_vld_out = 1'b0;
  logic [9:0] scan_dout = 10'd0;
  logic       out_vld;
  logic [9:0] out_dout;
  logic       out_src;
  logic       out_last;
  logic       err_gap;
  logic       err_orphan;

  logic       scan_en = 1'b0;
  logic       inject = 1'b0;
  logic       rst_set = 1'b1;
  logic [1:0] vld_set = 2'b00;
  logic       en_set = 1'b1;
  logic       inj_set = 1'b0;

  typedef struct {logic [9:0] d; logic s; logic l;} exp_t;
  typedef struct {logic [1:0] vld; logic g;} vec_t;

  exp_t       expq[$];
  logic [9:0] scanq[$];
  vec_t       tbl[9];

  int n_chk = 0;
  int n_fail = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  int n;
  int k;
  int bad;
  bit blk_done = 1'b0;
  bit last_seen = 1'b0;
  bit orphan_ok = 1'b0;
  bit orph_seen = 1'b0;

  mat_scan_arb #(.TAGD(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_din0     (req_din0),
    .req_din1     (req_din1),
    .req_rdy      (req_rdy),
    .scan_vld     (scan_vld),
    .scan_din     (scan_din),
    .scan_vld_out (scan_vld_out),
    .scan_dout    (scan_dout),
    .out_vld      (out_vld),
    .out_dout     (out_dout),
    .out_src      (out_src),
    .out_last     (out_last),
    .err_gap      (err_gap),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  // Scanner stand-in: returns accepted beats in order, one per cycle when enabled.
  always @(posedge clk) begin
    if (rst) begin
      scanq.delete();
      scan_vld_out <= 1'b0;
      scan_dout    <= 10'd0;
    end else begin
      if (scan_en && scanq.size() > 0) begin
        scan_vld_out <= 1'b1;
        scan_dout    <= scanq.pop_front();
      end else if (inject) begin
        scan_vld_out <= 1'b1;
        scan_dout    <= 10'h155;
      end else begin
        scan_vld_out <= 1'b0;
        scan_dout    <= 10'd0;
      end
      if (scan_vld) scanq.push_back(scan_din);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs at negedge, check combinational outputs, score beats.
  task automatic tick();
    logic       g;
    logic [9:0] ed;
    int         c;
    exp_t       e;
    @(negedge clk);
    rst      = rst_set;
    req_vld  = vld_set;
    scan_en  = en_set;
    inject   = inj_set;
    req_din0 = cnt0[9:0];
    req_din1 = 10'd512 + cnt1[9:0];
    #1;
    if (!rst) begin
      if (req_rdy == 2'b00) begin
        chk("idle_scan_vld", scan_vld, 0);
        chk("idle_scan_din", scan_din, 0);
      end else if (req_rdy == 2'b01 || req_rdy == 2'b10) begin
        g  = req_rdy[1];
        ed = req_vld[g] ? (g ? req_din1 : req_din0) : 10'd0;
        chk("mux_vld", scan_vld, req_vld[g]);
        chk("mux_din", scan_din, ed);
      end else begin
        chk("rdy_onehot", req_rdy, 2'b01);
      end
      for (int i = 0; i < 2; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          c   = (i == 0) ? cnt0 : cnt1;
          e.d = (i == 0) ? c[9:0] : 10'd512 + c[9:0];
          e.s = (i == 1);
          e.l = (c == 63);
          expq.push_back(e);
          if (c == 63) blk_done = 1'b1;
          if (i == 0) cnt0 = (cnt0 + 1) % 64;
          else        cnt1 = (cnt1 + 1) % 64;
        end
      end
    end
    if (out_vld) begin
      if (out_last) last_seen = 1'b1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_dout", out_dout, e.d);
        chk("out_src", out_src, e.s);
        chk("out_last", out_last, e.l);
      end else if (orphan_ok) begin
        orph_seen = 1'b1;
        chk("orphan_src", out_src, 0);
        chk("orphan_dout", out_dout, 10'h155);
        chk("orphan_last", out_last, 0);
      end else begin
        chk("unexpected_out", out_vld, 0);
      end
    end else begin
      chk("out_last_idle", out_last, 0);
    end
  endtask

  task automatic run_block(input string nm);
    n = 0;
    while (!blk_done && n < 200) begin tick(); n++; end
    chk(nm, blk_done, 1);
  endtask

  task automatic drain();
    vld_set = 2'b00;
    en_set  = 1'b1;
    n = 0;
    while (expq.size() > 0 && n < 400) begin tick(); n++; end
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1, "bench timed out");
  end

  initial begin
    tbl[0] = '{vld: 2'b11, g: 1'b0};
    tbl[1] = '{vld: 2'b11, g: 1'b1};
    tbl[2] = '{vld: 2'b11, g: 1'b0};
    tbl[3] = '{vld: 2'b11, g: 1'b1};
    tbl[4] = '{vld: 2'b01, g: 1'b0};
    tbl[5] = '{vld: 2'b01, g: 1'b0};
    tbl[6] = '{vld: 2'b11, g: 1'b1};
    tbl[7] = '{vld: 2'b10, g: 1'b1};
    tbl[8] = '{vld: 2'b11, g: 1'b0};

    // Reset state.
    tick(); tick();
    rst_set = 1'b0;
    tick();
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_scan_vld", scan_vld, 0);
    chk("rst_scan_din", scan_din, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_err_gap", err_gap, 0);
    chk("rst_err_orphan", err_orphan, 0);

    // Orphan beat before any grant.
    inj_set = 1'b1;
    tick();
    inj_set   = 1'b0;
    orphan_ok = 1'b1;
    tick(); tick();
    chk("orphan_seen", orph_seen, 1);
    chk("orphan_err", err_orphan, 1);
    orphan_ok = 1'b0;
    rst_set = 1'b1;
    tick(); tick();
    rst_set = 1'b0;
    tick();
    chk("orphan_err_cleared", err_orphan, 0);

    // Arbitration table: bubble, grant, then a full block each.
    for (int j = 0; j < 9; j++) begin
      vld_set  = tbl[j].vld;
      blk_done = 1'b0;
      tick();
      chk("bubble_rdy", req_rdy, 0);
      tick();
      chk("grant_rdy", req_rdy, tbl[j].g ? 2'b10 : 2'b01);
      run_block("table_block_done");
    end
    drain();

    // Gap of 5 cycles at beat 20 of a requester-0 block.
    vld_set  = 2'b01;
    blk_done = 1'b0;
    n = 0;
    while (cnt0 != 20 && n < 100) begin tick(); n++; end
    chk("gap_pre_err", err_gap, 0);
    vld_set = 2'b00;
    repeat (5) tick();
    chk("gap_err", err_gap, 1);
    vld_set = 2'b01;
    run_block("gap_block_done");
    vld_set = 2'b00;
    tick();
    chk("gap_sticky", err_gap, 1);
    chk("gap_bubble", req_rdy, 0);
    drain();

    // Tag-full stall with the scanner output held off.
    en_set   = 1'b0;
    vld_set  = 2'b01;
    blk_done = 1'b0;
    run_block("stall_blk_a");
    blk_done = 1'b0;
    run_block("stall_blk_b");
    blk_done = 1'b0;
    bad = 0;
    repeat (150) begin
      tick();
      if (req_rdy != 2'b00) bad++;
    end
    chk("stall_hold", bad, 0);
    en_set    = 1'b1;
    last_seen = 1'b0;
    n = 0;
    while (!last_seen && n < 200) begin tick(); n++; end
    chk("stall_pop_seen", last_seen, 1);
    k = 0;
    while (req_rdy == 2'b00 && k < 5) begin tick(); k++; end
    chk("stall_resume_cycles", k, 2);
    chk("stall_resume_rdy", req_rdy, 2'b01);
    run_block("stall_blk_c");
    vld_set = 2'b00;
    drain();

    // Reset in the middle of a block.
    en_set   = 1'b0;
    vld_set  = 2'b01;
    blk_done = 1'b0;
    n = 0;
    while (cnt0 != 30 && n < 100) begin tick(); n++; end
    chk("mid_beat30", cnt0, 30);
    rst_set = 1'b1;
    tick();
    rst_set = 1'b0;
    expq.delete();
    cnt0 = 0;
    cnt1 = 0;
    en_set = 1'b1;
    tick();
    chk("mid_rst_rdy", req_rdy, 0);
    chk("mid_rst_scan_vld", scan_vld, 0);
    chk("mid_rst_err_gap", err_gap, 0);
    chk("mid_rst_err_orphan", err_orphan, 0);
    blk_done = 1'b0;
    tick();
    chk("mid_regrant", req_rdy, 2'b01);
    run_block("mid_block_done");
    vld_set = 2'b00;
    tick();
    chk("mid_bubble", req_rdy, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
